// File: rtl/imm_ext_pipe.sv
// Pipelined rv32i/rv64i immediate generator: instr[31:7] + format select -> XLEN immediate,
// with a valid/ready handshake, a 2-entry skid buffer and a sideband tag. Optional IMM_ILLEGAL_SRC_EN adds out_err.
module imm_ext_pipe #(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inm,
  input  logic [2:0]       src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  inmExt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_SRC_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [2:0] SRC_I     = 3'd0;
  localparam logic [2:0] SRC_S     = 3'd1;
  localparam logic [2:0] SRC_B     = 3'd2;
  localparam logic [2:0] SRC_J     = 3'd3;
  localparam logic [2:0] SRC_U     = 3'd4;
  localparam logic [2:0] SRC_SHAMT = 3'd5;
  localparam logic [2:0] SRC_ZIMM  = 3'd6;
  localparam logic [2:0] SRC_RSVD  = 3'd7;

  // rv64 shifts take a 6-bit shamt (instr[25:20]); rv32 uses instr[24:20].
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  function automatic logic [XLEN-1:0] ext_imm(input logic [24:0] i, input logic [2:0] s);
    logic signed [31:0] s32;
    logic [XLEN-1:0]    r;
    s32 = '0;
    r   = '0;
    case (s)
      SRC_I: begin
        s32 = 32'($signed(i[24:13]));
        r   = XLEN'(s32);
      end
      SRC_S: begin
        s32 = 32'($signed({i[24:18], i[4:0]}));
        r   = XLEN'(s32);
      end
      SRC_B: begin
        s32 = 32'($signed({i[24], i[0], i[23:18], i[4:1], 1'b0}));
        r   = XLEN'(s32);
      end
      SRC_J: begin
        s32 = 32'($signed({i[24], i[12:5], i[13], i[23:14], 1'b0}));
        r   = XLEN'(s32);
      end
      SRC_U: begin
        s32 = $signed({i[24:5], 12'b0});
        r   = XLEN'(s32);
      end
      SRC_SHAMT: r = XLEN'(i[13 +: SHW]);
      SRC_ZIMM:  r = XLEN'(i[12:8]);
      default:   r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0]  new_imm;
  logic             in_fire;
  logic             out_fire;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;

  always_comb begin
    new_imm = ext_imm(inm, src);
  end

  // Handshake: a beat moves on an edge where valid and ready are both high. in_ready comes
  // straight from the skid-full flop, so it never depends combinationally on out_ready.
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign inmExt    = main_imm;
  assign out_tag   = main_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
    end else if (skid_valid) begin
      // Skid full implies main full and in_ready low; only a drain can happen.
      if (out_ready) begin
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid || out_ready) begin
        main_valid <= 1'b1;
        main_imm   <= new_imm;
        main_tag   <= in_tag;
      end else begin
        skid_valid <= 1'b1;
        skid_imm   <= new_imm;
        skid_tag   <= in_tag;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

`ifdef IMM_ILLEGAL_SRC_EN
  logic main_err;
  logic skid_err;

  // Error flag follows exactly the same load/move decisions as the immediate it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_err <= 1'b0;
      skid_err <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) main_err <= skid_err;
    end else if (in_fire) begin
      if (!main_valid || out_ready) main_err <= (src == SRC_RSVD);
      else                          skid_err <= (src == SRC_RSVD);
    end
  end

  assign out_err = main_err;
`endif

endmodule
